// File: rtl/sequence_player_if.sv
// Controller <-> sequence player bus: game controls in, LED pattern and status out.
interface sequence_player_if;
  logic       en;
  logic       clr;
  logic       next;
  logic [7:0] seed;
  logic [3:0] leds;
  logic       end_fpga;
  logic [3:0] round;
  logic       win;

  modport master (output en, clr, next, seed, input leds, end_fpga, round, win);
  modport slave  (input en, clr, next, seed, output leds, end_fpga, round, win);
endinterface

// File: rtl/sequence_player.sv
// Plays back a seeded LFSR sequence on four LEDs, one more element per round,
// signalling the controller when playback of the current round is complete.
module sequence_player #(
  parameter int ON_CYCLES  = 50_000_000,
  parameter int OFF_CYCLES = 25_000_000
) (
  input  logic               clock,
  input  logic               reset,
  sequence_player_if.slave   bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ON   = 3'd2;
  localparam logic [2:0] S_OFF  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    seed_q, seed_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    leds_q, leds_d;
  logic          end_q, end_d;
  logic [3:0]    round_q, round_d;
  logic          win_q, win_d;
  logic [7:0]    lfsr_next;

  function automatic logic [3:0] decode(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    timer_d = timer_q + TW'(1);
    leds_d  = leds_q;
    end_d   = end_q;
    round_d = round_q;
    win_d   = win_q;

    if (bus.next) begin
      if (round_q != 4'd15) round_d = round_q + 4'd1;
      else                  win_d   = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        leds_d  = 4'd0;
        end_d   = 1'b0;
        if (bus.en) state_d = S_LOAD;
      end
      S_LOAD: begin
        timer_d = '0;
        if (!bus.en) begin
          state_d = S_IDLE;
          leds_d  = 4'd0;
          end_d   = 1'b0;
        end else begin
          // leds are driven with the incoming element so they light on entry to ON
          lfsr_d  = seed_q;
          idx_d   = 4'd0;
          leds_d  = decode(seed_q[1:0]);
          state_d = S_ON;
        end
      end
      S_ON: begin
        if (!bus.en) begin
          state_d = S_IDLE;
          timer_d = '0;
          leds_d  = 4'd0;
          end_d   = 1'b0;
        end else if (timer_q == ON_LAST) begin
          state_d = S_OFF;
          timer_d = '0;
          leds_d  = 4'd0;
        end
      end
      S_OFF: begin
        if (!bus.en) begin
          state_d = S_IDLE;
          timer_d = '0;
          leds_d  = 4'd0;
          end_d   = 1'b0;
        end else if (timer_q == OFF_LAST) begin
          timer_d = '0;
          // round_q is sampled live so a mid-playback round change is honoured here
          if (idx_q == round_q) begin
            state_d = S_DONE;
            end_d   = 1'b1;
          end else begin
            state_d = S_ON;
            idx_d   = idx_q + 4'd1;
            lfsr_d  = lfsr_next;
            leds_d  = decode(lfsr_next[1:0]);
          end
        end
      end
      S_DONE: begin
        timer_d = '0;
        leds_d  = 4'd0;
        end_d   = 1'b1;
        if (!bus.en) begin
          state_d = S_IDLE;
          end_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        leds_d  = 4'd0;
        end_d   = 1'b0;
      end
    endcase

    if (bus.clr) begin
      seed_d  = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
      round_d = 4'd0;
      win_d   = 1'b0;
      state_d = S_IDLE;
      timer_d = '0;
      leds_d  = 4'd0;
      end_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      seed_q  <= 8'h01;
      lfsr_q  <= 8'h01;
      idx_q   <= 4'd0;
      timer_q <= '0;
      leds_q  <= 4'd0;
      end_q   <= 1'b0;
      round_q <= 4'd0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      leds_q  <= leds_d;
      end_q   <= end_d;
      round_q <= round_d;
      win_q   <= win_d;
    end
  end

  assign bus.leds     = leds_q;
  assign bus.end_fpga = end_q;
  assign bus.round    = round_q;
  assign bus.win      = win_q;

endmodule

// File: tb/tb_sequence_player.sv
// Scoreboard bench: expected lit runs are queued as playback is started and
// matched against each LED run the DUT actually produces.
module tb_sequence_player;

  localparam int ON  = 4;
  localparam int OFF = 2;

  typedef struct {
    logic [3:0] leds;
    int         len;
  } run_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests_run = 0;
  int   fails = 0;
  run_t exp_q[$];
  logic [3:0] run_val = 4'd0;
  int   run_len = 0;

  sequence_player_if bus ();

  sequence_player #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] decode(input logic [1:0] s);
    case (s)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0010;
      2'b10:   return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic push_run(input logic [3:0] l, input int len);
    run_t e;
    e.leds = l;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  // Run monitor: a run closes when leds change; the closed run is popped and compared.
  always @(negedge clock) begin
    if (bus.leds != 4'd0 && bus.leds == run_val) begin
      run_len++;
    end else begin
      if (run_val != 4'd0) begin
        if (exp_q.size() == 0) begin
          check_val("run_unexpected", int'(run_val), 0);
        end else begin
          run_t e;
          e = exp_q.pop_front();
          $display("[TB] run leds=%b len=%0d (exp leds=%b len=%0d)", run_val, run_len, e.leds, e.len);
          check_val("run_leds", int'(run_val), int'(e.leds));
          check_val("run_len", run_len, e.len);
        end
      end
      run_val = bus.leds;
      run_len = (bus.leds != 4'd0) ? 1 : 0;
    end
  end

  task automatic do_clr(input logic [7:0] s);
    @(negedge clock);
    bus.clr  = 1'b1;
    bus.seed = s;
    @(negedge clock);
    bus.clr  = 1'b0;
  endtask

  task automatic pulse_next();
    @(negedge clock);
    bus.next = 1'b1;
    @(negedge clock);
    bus.next = 1'b0;
  endtask

  task automatic play(input int r, input logic [7:0] sd);
    logic [7:0] l;
    int got;
    l = sd;
    for (int j = 0; j <= r; j++) begin
      push_run(decode(l[1:0]), ON);
      l = step(l);
    end
    @(negedge clock);
    bus.en = 1'b1;
    got = -1;
    for (int k = 0; k < 400 && got < 0; k++) begin
      @(negedge clock);
      if (bus.end_fpga) got = k;
    end
    check_val("end_edge", got, 1 + (r + 1) * (ON + OFF));
    check_val("done_leds", int'(bus.leds), 0);
    @(negedge clock);
    check_val("done_hold", int'(bus.end_fpga), 1);
    bus.en = 1'b0;
    @(negedge clock);
    check_val("done_exit", int'(bus.end_fpga), 0);
    $display("[TB] playback round=%0d seed=%h complete", r, sd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.en = 1'b0; bus.clr = 1'b0; bus.next = 1'b0; bus.seed = 8'h00;
    #12;
    check_val("rst_leds", int'(bus.leds), 0);
    check_val("rst_end", int'(bus.end_fpga), 0);
    check_val("rst_round", int'(bus.round), 0);
    check_val("rst_win", int'(bus.win), 0);
    @(negedge clock);
    reset = 1'b1;

    // Round 0, seed 01
    do_clr(8'h01);
    check_val("clr_round", int'(bus.round), 0);
    play(0, 8'h01);

    // Three rounds
    pulse_next();
    pulse_next();
    check_val("round_two", int'(bus.round), 2);
    play(2, 8'h01);

    // Zero seed behaves like seed 01
    do_clr(8'h00);
    check_val("zero_round", int'(bus.round), 0);
    play(0, 8'h01);

    // Abort in the second ON of round 1, then restart from element 0
    do_clr(8'h01);
    pulse_next();
    check_val("abort_round", int'(bus.round), 1);
    push_run(4'b0010, ON);
    push_run(4'b0100, 2);
    @(negedge clock);
    bus.en = 1'b1;
    repeat (9) @(negedge clock);
    bus.en = 1'b0;
    @(negedge clock);
    check_val("abort_leds", int'(bus.leds), 0);
    check_val("abort_end", int'(bus.end_fpga), 0);
    play(1, 8'h01);

    // Asynchronous reset during ON, between edges
    push_run(4'b0010, 2);
    @(negedge clock);
    bus.en = 1'b1;
    repeat (3) @(negedge clock);
    check_val("pre_arst_leds", int'(bus.leds), 2);
    #2 reset = 1'b0;
    #1;
    check_val("arst_leds", int'(bus.leds), 0);
    check_val("arst_end", int'(bus.end_fpga), 0);
    check_val("arst_round", int'(bus.round), 0);
    @(negedge clock);
    bus.en = 1'b0;
    reset  = 1'b1;

    // Win after saturating the round counter
    do_clr(8'h01);
    repeat (15) pulse_next();
    check_val("sat_round", int'(bus.round), 15);
    check_val("sat_win", int'(bus.win), 0);
    pulse_next();
    check_val("win_round", int'(bus.round), 15);
    check_val("win_flag", int'(bus.win), 1);
    do_clr(8'h01);
    check_val("clr_win", int'(bus.win), 0);
    check_val("clr_round2", int'(bus.round), 0);

    repeat (3) @(negedge clock);
    check_val("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 Parameter ON_CYCLES, default 50_000_000, number of clock cycles each sequence element is lit (legal range >=1).
REQ-002 Parameter OFF_CYCLES, default 25_000_000, number of dark cycles after each element (legal range >=1).
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  playback enable, driven by the game controller during the FPGA-play phase.
REQ-006 clr  input  1  synchronous game clear, driven by the game controller in its init phase.
REQ-007 next  input  1  single-cycle pulse that advances to the next round.
REQ-008 seed  input  8  LFSR seed, captured on clr.
REQ-009 leds  output  4  one-hot pattern of the current element; 0 when dark.
REQ-010 end_fpga  output  1  playback-complete status to the controller.
REQ-011 round  output  4  current round index, 0..15.
REQ-012 win  output  1  sticky flag: all 16 rounds completed.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have states IDLE, LOAD, ON, OFF and DONE.
REQ-015 On clr=1, seed_reg SHALL load seed, or 8'h01 if seed==0, and round, win and the FSM SHALL return to round=0, win=0 and IDLE; clr SHALL override en and next in that cycle.
REQ-016 In IDLE, en=1 SHALL move the FSM to LOAD, and leds and end_fpga SHALL be 0.
REQ-017 LOAD SHALL last one cycle, set lfsr<=seed_reg and idx<=0, then move to ON.
REQ-018 In ON, leds SHALL equal the one-hot decode of lfsr[1:0] (00->0001, 01->0010, 10->0100, 11->1000) for exactly ON_CYCLES cycles, then the FSM SHALL move to OFF.
REQ-019 In OFF, leds SHALL be 0 for exactly OFF_CYCLES cycles.
REQ-020 At the end of OFF, if idx==round the FSM SHALL move to DONE; otherwise idx SHALL increment, lfsr SHALL step once, and the FSM SHALL move to ON.
REQ-021 Each LFSR step SHALL compute lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-022 Because every playback restarts from seed_reg, round r SHALL replay the same first r+1 elements.
REQ-023 In DONE, end_fpga SHALL be 1 and leds 0, held while en=1; en=0 SHALL move the FSM to IDLE and clear end_fpga on that edge.
REQ-024 If en falls in LOAD, ON or OFF, the FSM SHALL abort to IDLE on the next edge, with leds=0 and end_fpga=0.
REQ-025 next=1 with round<15 SHALL increment round, in any FSM state.
REQ-026 next=1 with round==15 SHALL leave round at 15 and set win=1.
REQ-027 A round change during active playback SHALL take effect at the next idx==round comparison.
REQ-028 Timing: with the edge that samples en=1 counted as edge 0, leds SHALL go non-zero after edge 1, and end_fpga SHALL rise after edge 1+(round+1)*(ON_CYCLES+OFF_CYCLES).
REQ-029 The on/off timer SHALL be wide enough for max(ON_CYCLES,OFF_CYCLES) and SHALL clear on every state change.

Reset
REQ-030 While reset=0, outputs SHALL be leds=0, end_fpga=0, round=0 and win=0, and internal state SHALL be FSM=IDLE, seed_reg=8'h01, lfsr=8'h01, idx=0 and timer=0.
REQ-031 Reset assertion mid-playback SHALL force these values immediately, without waiting for a clock edge.
REQ-032 Release SHALL take effect on the first rising edge with reset=1.

Verification (ON_CYCLES=4, OFF_CYCLES=2)
REQ-033 Round 0: clr with seed=8'h01, then en=1 -> leds=0010 during edges 1-5, 0 during edges 5-7, end_fpga=1 after edge 7.
REQ-034 Three rounds: two next pulses, then en=1 -> leds sequence 0010, 0100, 0001, each lit 4 cycles, and end_fpga rises after edge 19.
REQ-035 Win: 15 next pulses (round=15), then one more -> round stays 15 and win=1; a following clr -> win=0 and round=0.
REQ-036 Abort: en dropped in the second ON of round 1 -> leds=0 and FSM=IDLE next edge; re-raising en restarts from element 0x0010.
REQ-037 Zero seed: clr with seed=8'h00, round 0, en=1 -> leds=0010, identical to seed 8'h01.
REQ-038 Async reset: reset=0 during ON between edges -> leds=0, end_fpga=0 and round=0 before the next edge.
